// File: rtl/bus_seq_datapath.sv
// Single-bus datapath with register file, Y, 2*WIDTH Z and HI/LO, driven by a
// T-state sequencer that runs one Ra <= Rb op Rc instruction per start pulse.
module bus_seq_datapath #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 16,
  parameter int R0_ZERO = 0
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  input  logic [3:0]               op,
  input  logic [$clog2(NREGS)-1:0] ra,
  input  logic [$clog2(NREGS)-1:0] rb,
  input  logic [$clog2(NREGS)-1:0] rc,
  input  logic                     ext_we,
  input  logic [$clog2(NREGS)-1:0] ext_addr,
  input  logic [WIDTH-1:0]         ext_data,
  input  logic [$clog2(NREGS)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic [WIDTH-1:0]         hi,
  output logic [WIDTH-1:0]         lo,
  output logic [2*WIDTH-1:0]       z,
  output logic                     busy,
  output logic                     done,
  output logic                     div0
);

  localparam int AW = $clog2(NREGS);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2,  OP_OR  = 4'd3;
  localparam logic [3:0] OP_SHL = 4'd4,  OP_SHR = 4'd5,  OP_ROL = 4'd6,  OP_ROR = 4'd7;
  localparam logic [3:0] OP_NEG = 4'd8,  OP_NOT = 4'd9,  OP_MUL = 4'd10, OP_DIV = 4'd11;

  typedef enum logic [2:0] {S_IDLE, S_T3, S_T4, S_MD, S_T5} state_t;

  state_t             r_state;
  logic [3:0]         r_op;
  logic [AW-1:0]      r_ra, r_rb, r_rc;
  logic [WIDTH-1:0]   r_regs [NREGS];
  logic [WIDTH-1:0]   r_y, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_z;
  logic               r_busy, r_done, r_div0;

  // Multiply/divide unit: r_md_a is the running high word (partial product or
  // remainder), r_md_q the low word (multiplier or dividend/quotient).
  logic [WIDTH-1:0]   r_md_a, r_md_q, r_md_b, r_md_dividend;
  logic               r_md_neg_q, r_md_neg_r, r_md_bzero;
  logic [SW-1:0]      r_md_cnt;

  logic [WIDTH-1:0]   w_bus, w_alu;
  logic [SW-1:0]      w_amt;
  logic               w_is_md;
  logic [WIDTH:0]     w_mul_sum, w_div_shift, w_div_trial;
  logic               w_div_ok;
  logic [WIDTH-1:0]   w_md_a_nx, w_md_q_nx, w_quo, w_rem, w_abs_y, w_abs_bus;
  logic [2*WIDTH-1:0] w_prod, w_md_res;

  function automatic logic [WIDTH-1:0] read_reg(input logic [AW-1:0] idx);
    if (R0_ZERO != 0 && idx == '0) return '0;
    return r_regs[idx];
  endfunction

  assign w_is_md = (r_op == OP_MUL) || (r_op == OP_DIV);

  // NOTE: every output of a combinational block gets a default first so that no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    w_bus = '0;
    case (r_state)
      S_T3:    w_bus = read_reg(r_rb);
      S_T4:    w_bus = read_reg(r_rc);
      S_T5:    w_bus = r_z[WIDTH-1:0];
      default: w_bus = '0;
    endcase
  end

  assign w_amt = w_bus[SW-1:0];

  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD:  w_alu = r_y + w_bus;
      OP_SUB:  w_alu = r_y - w_bus;
      OP_AND:  w_alu = r_y & w_bus;
      OP_OR:   w_alu = r_y | w_bus;
      OP_SHL:  w_alu = r_y << w_amt;
      OP_SHR:  w_alu = r_y >> w_amt;
      OP_ROL:  w_alu = (r_y << w_amt) | (r_y >> (WIDTH - int'(w_amt)));
      OP_ROR:  w_alu = (r_y >> w_amt) | (r_y << (WIDTH - int'(w_amt)));
      OP_NEG:  w_alu = -r_y;
      OP_NOT:  w_alu = ~r_y;
      default: w_alu = '0;
    endcase
  end

  // Both MUL and DIV work on magnitudes; signs are reapplied on the last step.
  assign w_abs_y   = r_y[WIDTH-1]   ? -r_y   : r_y;
  assign w_abs_bus = w_bus[WIDTH-1] ? -w_bus : w_bus;

  assign w_mul_sum   = r_md_q[0] ? ({1'b0, r_md_a} + {1'b0, r_md_b}) : {1'b0, r_md_a};
  assign w_div_shift = {r_md_a, r_md_q[WIDTH-1]};
  assign w_div_trial = w_div_shift - {1'b0, r_md_b};
  assign w_div_ok    = ~w_div_trial[WIDTH];

  always_comb begin
    w_md_a_nx = w_mul_sum[WIDTH:1];
    w_md_q_nx = {w_mul_sum[0], r_md_q[WIDTH-1:1]};
    if (r_op == OP_DIV) begin
      w_md_a_nx = w_div_ok ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
      w_md_q_nx = {r_md_q[WIDTH-2:0], w_div_ok};
    end
  end

  assign w_prod = {w_md_a_nx, w_md_q_nx};
  assign w_quo  = r_md_neg_q ? -w_md_q_nx : w_md_q_nx;
  assign w_rem  = r_md_neg_r ? -w_md_a_nx : w_md_a_nx;

  always_comb begin
    w_md_res = r_md_neg_q ? -w_prod : w_prod;
    if (r_op == OP_DIV)
      w_md_res = r_md_bzero ? {r_md_dividend, {WIDTH{1'b1}}} : {w_rem, w_quo};
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state       <= S_IDLE;
      r_op          <= '0;
      r_ra          <= '0;
      r_rb          <= '0;
      r_rc          <= '0;
      r_y           <= '0;
      r_z           <= '0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_div0        <= 1'b0;
      r_md_a        <= '0;
      r_md_q        <= '0;
      r_md_b        <= '0;
      r_md_dividend <= '0;
      r_md_neg_q    <= 1'b0;
      r_md_neg_r    <= 1'b0;
      r_md_bzero    <= 1'b0;
      r_md_cnt      <= '0;
      // NOTE: the register file is cleared by reset because software relies on
      // all registers reading zero afterwards; this keeps it in flops, not RAM.
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_ra    <= ra;
            r_rb    <= rb;
            r_rc    <= rc;
            r_div0  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_T3;
          end else if (ext_we && (R0_ZERO == 0 || ext_addr != '0)) begin
            r_regs[ext_addr] <= ext_data;
          end
        end
        S_T3: begin
          r_y     <= w_bus;
          r_state <= S_T4;
        end
        S_T4: begin
          if (w_is_md) begin
            r_md_a        <= '0;
            r_md_q        <= w_abs_y;
            r_md_b        <= w_abs_bus;
            r_md_dividend <= r_y;
            r_md_neg_q    <= r_y[WIDTH-1] ^ w_bus[WIDTH-1];
            r_md_neg_r    <= r_y[WIDTH-1];
            r_md_bzero    <= (w_bus == '0);
            r_md_cnt      <= '0;
            r_state       <= S_MD;
          end else begin
            r_z     <= {{WIDTH{1'b0}}, w_alu};
            r_state <= S_T5;
          end
        end
        S_MD: begin
          r_md_a   <= w_md_a_nx;
          r_md_q   <= w_md_q_nx;
          r_md_cnt <= r_md_cnt + 1'b1;
          if (r_md_cnt == SW'(WIDTH - 1)) begin
            r_z     <= w_md_res;
            r_div0  <= (r_op == OP_DIV) && r_md_bzero;
            r_state <= S_T5;
          end
        end
        S_T5: begin
          if (w_is_md) begin
            r_hi <= r_z[2*WIDTH-1:WIDTH];
            r_lo <= r_z[WIDTH-1:0];
          end else if (R0_ZERO == 0 || r_ra != '0) begin
            r_regs[r_ra] <= w_bus;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_data = read_reg(rd_addr);
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign z       = r_z;
  assign busy    = r_busy;
  assign done    = r_done;
  assign div0    = r_div0;

endmodule

// File: tb/tb_bus_seq_datapath.sv
// Directed plus randomized checks of bus_seq_datapath against an arithmetic
// reference model; two instances cover R0_ZERO = 0 and R0_ZERO = 1.
module tb_bus_seq_datapath;

  localparam int W = 32;
  localparam int N = 16;

  logic clk = 1'b0;
  logic clr, start, ext_we;
  logic [3:0]  op, ra, rb, rc, ext_addr, rd_addr;
  logic [31:0] ext_data;
  logic [31:0] rd_data0, hi0, lo0, rd_data1, hi1, lo1;
  logic [63:0] z0, z1;
  logic busy0, busy1, done0, done1, div0_0, div0_1;

  always #5 clk = ~clk;

  bus_seq_datapath #(.WIDTH(W), .NREGS(N), .R0_ZERO(0)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data), .rd_addr(rd_addr),
    .rd_data(rd_data0), .hi(hi0), .lo(lo0), .z(z0), .busy(busy0), .done(done0), .div0(div0_0));

  bus_seq_datapath #(.WIDTH(W), .NREGS(N), .R0_ZERO(1)) dut_z (
    .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data), .rd_addr(rd_addr),
    .rd_data(rd_data1), .hi(hi1), .lo(lo1), .z(z1), .busy(busy1), .done(done1), .div0(div0_1));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state, index 0 = plain register file, index 1 = hard-wired R0.
  logic [31:0] m [2][N];
  logic [31:0] mhi [2];
  logic [31:0] mlo [2];
  bit          mdz [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rdm(input int d, input logic [3:0] idx);
    if (d == 1 && idx == 4'd0) return 32'h0;
    return m[d][idx];
  endfunction

  function automatic logic [31:0] rot_left(input logic [31:0] v, input int n);
    logic [31:0] t = v;
    for (int i = 0; i < n; i++) t = {t[30:0], t[31]};
    return t;
  endfunction

  function automatic logic [31:0] rot_right(input logic [31:0] v, input int n);
    logic [31:0] t = v;
    for (int i = 0; i < n; i++) t = {t[0], t[31:1]};
    return t;
  endfunction

  function automatic void model_op(input logic [3:0] f_op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] lo_o, output logic [31:0] hi_o,
                                   output bit md, output bit dz);
    int     amt;
    longint sa, sb, p, q, r;
    amt = int'(b[4:0]);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lo_o = 32'h0; hi_o = 32'h0; md = 1'b0; dz = 1'b0;
    case (f_op)
      4'd0:  lo_o = a + b;
      4'd1:  lo_o = a - b;
      4'd2:  lo_o = a & b;
      4'd3:  lo_o = a | b;
      4'd4:  lo_o = a << amt;
      4'd5:  lo_o = a >> amt;
      4'd6:  lo_o = rot_left(a, amt);
      4'd7:  lo_o = rot_right(a, amt);
      4'd8:  lo_o = 32'h0 - a;
      4'd9:  lo_o = ~a;
      4'd10: begin
        md = 1'b1;
        p = sa * sb;
        lo_o = p[31:0];
        hi_o = p[63:32];
      end
      4'd11: begin
        md = 1'b1;
        if (b == 32'h0) begin
          dz = 1'b1;
          lo_o = 32'hFFFF_FFFF;
          hi_o = a;
        end else begin
          q = sa / sb;
          r = sa % sb;
          lo_o = q[31:0];
          hi_o = r[31:0];
        end
      end
      default: lo_o = 32'h0;
    endcase
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) m[d][i] = 32'h0;
      mhi[d] = 32'h0;
      mlo[d] = 32'h0;
      mdz[d] = 1'b0;
    end
  endtask

  // Entered and left on a falling edge.
  task automatic ext_load(input logic [3:0] addr, input logic [31:0] data);
    ext_we = 1'b1; ext_addr = addr; ext_data = data;
    @(negedge clk);
    ext_we = 1'b0;
    m[0][addr] = data;
    if (addr != 4'd0) m[1][addr] = data;
  endtask

  task automatic sweep();
    for (int i = 0; i < N; i++) begin
      rd_addr = 4'(i);
      #1;
      check($sformatf("sweep0_r%0d", i), rd_data0, rdm(0, 4'(i)));
      check($sformatf("sweep1_r%0d", i), rd_data1, rdm(1, 4'(i)));
    end
  endtask

  // inject: 0 none, 1 stray start while busy, 2 ext_we while busy, 3 ext_we with start.
  // Returns on the falling edge of the done cycle, except inject 1 which then
  // watches a few more cycles for a spurious second done.
  task automatic run_op(input logic [3:0] f_op, input logic [3:0] f_ra, input logic [3:0] f_rb,
                        input logic [3:0] f_rc, input int inject);
    logic [31:0] rl [2];
    logic [31:0] rh [2];
    bit          dz [2];
    bit          md;
    int          cnt;
    bit          extra;
    for (int d = 0; d < 2; d++)
      model_op(f_op, rdm(d, f_rb), rdm(d, f_rc), rl[d], rh[d], md, dz[d]);

    start = 1'b1; op = f_op; ra = f_ra; rb = f_rb; rc = f_rc; rd_addr = f_ra;
    if (inject == 3) begin
      ext_we = 1'b1; ext_addr = 4'($urandom); ext_data = $urandom;
    end
    @(negedge clk);
    start = 1'b0; ext_we = 1'b0;
    op = 4'($urandom); ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
    check("busy_rise", busy0, 1'b1);
    check("div0_cleared", {div0_0, div0_1}, 2'b00);

    cnt = 1;
    while (!done0 && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (cnt == 2 && inject == 1) begin
        start = 1'b1; op = 4'($urandom); ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom);
      end
      if (cnt == 2 && inject == 2) begin
        ext_we = 1'b1; ext_addr = 4'($urandom); ext_data = $urandom;
      end
      if (cnt == 3) begin
        start = 1'b0; ext_we = 1'b0;
      end
    end
    start = 1'b0; ext_we = 1'b0;
    check("latency", 64'(cnt - 1), md ? 64'd35 : 64'd3);
    check("done_z", done1, 1'b1);
    check("busy_fall", {busy0, busy1}, 2'b00);

    for (int d = 0; d < 2; d++) begin
      if (md) begin
        mhi[d] = rh[d];
        mlo[d] = rl[d];
        mdz[d] = dz[d];
      end else begin
        mdz[d] = 1'b0;
        if (!(d == 1 && f_ra == 4'd0)) m[d][f_ra] = rl[d];
      end
    end
    check("rd_ra0", rd_data0, rdm(0, f_ra));
    check("rd_ra1", rd_data1, rdm(1, f_ra));
    check("hi0", hi0, mhi[0]);
    check("lo0", lo0, mlo[0]);
    check("hi1", hi1, mhi[1]);
    check("lo1", lo1, mlo[1]);
    check("z0", z0, md ? {rh[0], rl[0]} : {32'h0, rl[0]});
    check("z1", z1, md ? {rh[1], rl[1]} : {32'h0, rl[1]});
    check("div0", {div0_0, div0_1}, {mdz[0], mdz[1]});

    if (inject == 1) begin
      extra = 1'b0;
      repeat (6) begin
        @(negedge clk);
        extra |= done0 | done1 | busy0;
      end
      check("no_second_done", extra, 1'b0);
    end
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    clr = 1'b1; start = 1'b0; ext_we = 1'b0; op = '0; ra = '0; rb = '0; rc = '0;
    ext_addr = '0; ext_data = '0; rd_addr = '0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    model_clear();
    check("reset_busy", {busy0, busy1}, 2'b00);
    check("reset_done", {done0, done1}, 2'b00);
    check("reset_hilo", {hi0, lo0}, 64'h0);
    check("reset_z", z0, 64'h0);
    check("reset_div0", div0_0, 1'b0);
    sweep();

    // ADD wraps, ROR amount taken modulo WIDTH.
    @(negedge clk);
    ext_load(4'd1, 32'hFFFF_FFFF);
    ext_load(4'd2, 32'd2);
    run_op(4'd0, 4'd3, 4'd1, 4'd2, 0);
    check("add_wrap", rd_data0, 32'h1);
    @(negedge clk);
    ext_load(4'd4, 32'h8000_0001);
    ext_load(4'd5, 32'd33);
    run_op(4'd7, 4'd6, 4'd4, 4'd5, 0);
    check("ror33", rd_data0, 32'hC000_0000);

    // Signed MUL with a stray start while busy.
    @(negedge clk);
    ext_load(4'd1, 32'hFFFF_FFFE);
    ext_load(4'd2, 32'd3);
    run_op(4'd10, 4'd7, 4'd1, 4'd2, 1);
    check("mul_hi", hi0, 32'hFFFF_FFFF);
    check("mul_lo", lo0, 32'hFFFF_FFFA);
    sweep();

    // Signed DIV with an external write attempted while busy.
    @(negedge clk);
    ext_load(4'd1, 32'hFFFF_FFF9);
    ext_load(4'd2, 32'd2);
    run_op(4'd11, 4'd8, 4'd1, 4'd2, 2);
    check("div_lo", lo0, 32'hFFFF_FFFD);
    check("div_hi", hi0, 32'hFFFF_FFFF);
    sweep();

    // Divide by zero, then a start (with a coincident ext_we) clears div0.
    @(negedge clk);
    ext_load(4'd1, 32'd5);
    ext_load(4'd2, 32'd0);
    run_op(4'd11, 4'd9, 4'd1, 4'd2, 0);
    check("div0_lo", lo0, 32'hFFFF_FFFF);
    check("div0_hi", hi0, 32'd5);
    check("div0_flag", div0_0, 1'b1);
    run_op(4'd0, 4'd9, 4'd1, 4'd1, 3);
    sweep();

    // Back-to-back: start asserted in the done cycle.
    @(negedge clk);
    run_op(4'd1, 4'd10, 4'd9, 4'd1, 0);
    run_op(4'd8, 4'd11, 4'd10, 4'd10, 0);
    run_op(4'd12, 4'd12, 4'd1, 4'd1, 0);
    sweep();

    // Hard-wired R0 versus writable R0.
    @(negedge clk);
    ext_load(4'd0, 32'h1234);
    ext_load(4'd1, 32'h10);
    ext_load(4'd2, 32'h20);
    rd_addr = 4'd0;
    #1;
    check("r0_ext0", rd_data0, 32'h1234);
    check("r0_ext1", rd_data1, 32'h0);
    run_op(4'd0, 4'd0, 4'd1, 4'd2, 0);
    check("r0_add0", rd_data0, 32'h30);
    check("r0_add1", rd_data1, 32'h0);

    // Reset in the tenth MD cycle of a DIV aborts it.
    @(negedge clk);
    ext_load(4'd1, 32'hFFFF_FFF9);
    ext_load(4'd2, 32'd2);
    start = 1'b1; op = 4'd11; ra = 4'd3; rb = 4'd1; rc = 4'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("md_busy_before_clr", busy0, 1'b1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    check("abort_busy", {busy0, busy1}, 2'b00);
    check("abort_done", {done0, done1}, 2'b00);
    check("abort_hilo", {hi0, lo0}, 64'h0);
    check("abort_z", z0, 64'h0);
    begin
      bit late = 1'b0;
      repeat (40) begin
        @(negedge clk);
        late |= done0 | busy0;
      end
      check("abort_no_done", late, 1'b0);
    end
    sweep();

    // Randomized operations.
    @(negedge clk);
    for (int it = 0; it < 60; it++) begin
      repeat (3) ext_load(4'($urandom), rand_val());
      run_op(4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 4'($urandom),
             int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      if (it % 10 == 9) begin
        sweep();
        @(negedge clk);
      end
    end
    sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_seq_datapath.md
# bus_seq_datapath

Parametrised successor to the single-bus CPU datapath. It has a general register file, Y, a 2×WIDTH Z register, and HI/LO, all moved over one internal bus. A built-in T-state sequencer executes a complete register-register instruction (`Ra <= Rb op Rc`) from a single `start` pulse, so the testbench no longer drives per-cycle `Rxin`/`Rxout` strobes. It adds a multi-cycle signed multiply/divide unit feeding HI/LO, and an optional hard-wired zero R0.

## Interface
- `WIDTH`, 32, datapath/register width (≥ 8, power of 2)
- `NREGS`, 16, number of general registers (power of 2, ≥ 4)
- `R0_ZERO`, 0, 1 = R0 always reads 0 and ignores writes
- `clk`  in  1  clock; all state changes on the rising edge
- `clr`  in  1  reset, synchronous, active-high
- `start`  in  1  request one operation; sampled only in IDLE
- `op`  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR (logical), 6 ROL, 7 ROR, 8 NEG, 9 NOT, 10 MUL, 11 DIV; 12–15 reserved (NOP)
- `ra`, `rb`, `rc`  in  $clog2(NREGS)  destination and source register indices
- `ext_we`  in  1  external register load strobe
- `ext_addr`  in  $clog2(NREGS)  external load index
- `ext_data`  in  WIDTH  external load data
- `rd_addr`  in  $clog2(NREGS)  observation read index
- `rd_data`  out  WIDTH  combinational `R[rd_addr]`
- `hi`, `lo`  out  WIDTH  HI/LO registers
- `z`  out  2*WIDTH  Z register
- `busy`  out  1  high whenever the sequencer is not in IDLE
- `done`  out  1  one-cycle pulse on completion
- `div0`  out  1  set by DIV with divisor 0; cleared by the next accepted start

## Operation
- FSM states: IDLE, T3, T4, MD, T5.
  - IDLE → T3 on `start`.
  - T3: bus = `R[rb]`; Y <= bus; → T4.
  - T4, single-cycle ops: bus = `R[rc]`; Z <= {0, ALU(Y, bus)}; → T5.
  - T4, MUL/DIV: load operands into the MD unit; → MD.
  - MD: one shift-add (MUL) or restoring (DIV) step per cycle. Exactly WIDTH cycles, then Z <= {upper, lower} result; → T5.
  - T5, single-cycle ops: `R[ra]` <= Z[WIDTH-1:0].
  - T5, MUL/DIV: HI <= Z upper half and LO <= Z lower half; the register file is unchanged.
  - T5 sets `done`; → IDLE.
- Arithmetic:
  - ADD/SUB/NEG: modulo 2^WIDTH, no flags.
  - Shifts and rotates: amount = `Rc[$clog2(WIDTH)-1:0]`.
  - NEG and NOT use Y only.
- MUL: signed × signed, full 2*WIDTH product in {HI, LO}.
- DIV: signed.
  - LO = quotient, truncated toward zero.
  - HI = remainder, taking the sign of the dividend.
  - Divisor 0: LO = all ones, HI = dividend, `div0` = 1.
- Reserved op codes: run T3/T4/T5 with Z <= 0 and write 0 to `R[ra]`.
- `ra`, `rb`, `rc`, `op` are captured at start acceptance; later changes have no effect. `ra == rb == rc` is legal.
- `ext_we`:
  - Writes `ext_data` to `R[ext_addr]` only in IDLE with `start` low.
  - Ignored while busy, or when `start` is high in the same cycle.
- `R0_ZERO = 1`: every write to R0 (sequencer or external) is discarded; R0 reads 0 everywhere.

## Timing
- Reset: on a `clr` edge, all registers, Y, Z, HI, LO, and `div0` become 0; the FSM goes to IDLE; `busy` = 0 and `done` = 0 from that edge. `clr` overrides `start` and `ext_we`.
- `clr` during T3/T4/MD/T5 aborts the operation with no register-file, HI or LO write.
- Latency, start sampled at edge k:
  - Single-cycle ops: `done` = 1 in the cycle after edge k+3; the `R[ra]` result is visible on `rd_data` in the same cycle.
  - MUL/DIV: `done` in the cycle after edge k+3+WIDTH.
- `busy` rises after edge k and falls at the edge that raises `done`.
- `start` high in the `done` cycle is accepted (back-to-back). `start` while busy is ignored and not queued.
- `done` is exactly one cycle wide.

## Test plan
- Reset values: pulse `clr` → `rd_data`, `hi`, `lo`, `z` = 0 for all addresses; `busy` = 0; `done` = 0.
- ADD wrap: ext-load R1 = 0xFFFFFFFF, R2 = 2; ADD ra=3 → `done` 3 cycles after start, R3 = 0x00000001. ROR R4 = 0x80000001 by R5 = 33 → 0xC0000000.
- MUL signed: R1 = 0xFFFFFFFE (−2), R2 = 0x00000003; MUL → HI = 0xFFFFFFFF, LO = 0xFFFFFFFA; `done` at 3+32 cycles; register file unchanged.
- DIV: R1 = −7, R2 = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Divisor 0 with dividend 5 → LO = 0xFFFFFFFF, HI = 5, `div0` = 1; next start clears `div0`.
- Mid-op reset and ignored start: during a DIV, assert `clr` at MD cycle 10 → IDLE next cycle with HI = LO = 0. A separately issued `start` while busy produces no second `done`.
- `R0_ZERO = 1`: ext-write R0 = 0x1234 then ADD ra=0 → R0 reads 0. With `R0_ZERO = 0`, the same sequence gives R0 = 0x1234 and then the sum.
